fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the synchronous instruction ROM.
- Each cycle it drives the word address into the ROM and captures the PC that was issued.
- One cycle later it pairs the ROM data with that PC and presents the pair to decode over a valid/ready handshake.
- It handles downstream back-pressure, branch/flush redirects and a fetch-enable gate, so no instruction is lost or duplicated.

Parameters:
- ADDRESS_WIDTH, 12, word-address width; must match the ROM address width.
- DATA_WIDTH, 32, instruction width; must match the ROM data width.
- RESET_PC, 0, first word address fetched after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- romAddr  out  ADDRESS_WIDTH  address to ROM; combinational from internal state; ROM registers it at the next edge.
- romData  in  DATA_WIDTH  ROM read data; equals Mem[romAddr of previous cycle].
- fetchEnable  in  1  when low, no new fetch is issued; an instruction already held is preserved.
- redirectValid  in  1  flush and restart fetch at redirectPC (branch mispredict/exception).
- redirectPC  in  ADDRESS_WIDTH  redirect target word address.
- outValid  out  1  outInstr/outPC valid to decode.
- outReady  in  1  decode accepts this cycle.
- outInstr  out  DATA_WIDTH  fetched instruction (romData passthrough).
- outPC  out  ADDRESS_WIDTH  word address of outInstr.
- fetchCount  out  32  number of handshakes completed (outValid && outReady) since reset.

Behaviour:
- State:
  - pcReg: next address to issue.
  - respPC: address whose data is on romData this cycle.
  - respValid: romData corresponds to a live request.
  - fetchCount.
- Reset (synchronous, takes priority over everything):
  - pcReg=RESET_PC, respPC=RESET_PC, respValid=0, fetchCount=0.
  - During a reset cycle romAddr=RESET_PC and outValid=0.
- Output signals:
  - outValid = respValid && !redirectValid.
  - outInstr = romData.
  - outPC = respPC.
- stall = outValid && !outReady.
- Per-cycle priority, after reset: redirect > stall > disabled > advance.
  - Redirect (redirectValid=1):
    - romAddr=redirectPC; respPC<=redirectPC; respValid<=1; pcReg<=redirectPC+1.
    - The current output is squashed: outValid=0, no handshake and no count, even if outReady=1.
  - Stall:
    - romAddr=respPC, so the ROM re-reads the same word and romData holds next cycle.
    - respPC, respValid and pcReg are unchanged.
  - Disabled (fetchEnable=0, not stalled):
    - romAddr=pcReg; respValid<=0; pcReg and respPC are unchanged.
    - A pending valid output is consumed this cycle by definition (it is not stalled).
  - Advance:
    - romAddr=pcReg; respPC<=pcReg; respValid<=1; pcReg<=pcReg+1.
- Latency:
  - First outValid is the 2nd cycle after reset deasserts: cycle 1 issues RESET_PC, cycle 2 presents it.
  - The cycle after a redirect presents redirectPC.
  - Sustained throughput with outReady=1 is 1 instruction/cycle.
- Arithmetic:
  - pcReg+1 is modulo 2^ADDRESS_WIDTH; the address after 2^ADDRESS_WIDTH-1 is 0 (wrap, no error).
  - fetchCount is modulo 2^32.
- Ordering: PCs delivered to decode are strictly sequential except immediately after a redirect. There are no gaps or duplicates across any stall pattern.
- outInstr/outPC must not change while outValid=1 and outReady=0, unless redirectValid or reset is asserted.

Decomposition:
- Shared package proc_pkg holds:
  - ADDR_W=12, INSTR_W=32, RESET_PC=0, so ROM, fetch and decode agree.
  - The instruction word typedef and the PC typedef.
- No sub-module is needed; the next-address mux and PC increment are inline. The ROM is instantiated at the processor top, not inside fetch_unit.

Test Plan:
- Reset then run: ROM holds Mem[i]=i+100, outReady=1, fetchEnable=1, reset deasserted at t0 -> outValid first high at t0+2 with outPC=0 and outInstr=100, then outPC=1,2,3 with 101,102,103 on consecutive cycles.
- Back-pressure: hold outReady=0 for 3 cycles while outPC=5 -> outPC=5 and outInstr=105 stable for all 3 cycles, romAddr=5; after release, next outputs are 6 then 7, with no duplicate and no skip; fetchCount increments once for PC 5.
- Redirect: while streaming at outPC=10, assert redirectValid with redirectPC=40 for 1 cycle and outReady=1 -> outValid=0 that cycle, PC 10 is not counted, next cycle outPC=40/140, then 41.
- Redirect during stall: outReady=0 at outPC=7 with redirectValid=1 and redirectPC=2 -> next cycle outPC=2/102; PC 7 is never accepted.
- Wrap and enable: redirect to 4095 with ADDRESS_WIDTH=12 -> outputs 4095 then 0. Drop fetchEnable for 2 cycles -> outValid low for 2 cycles, resumes at the next sequential PC.
- Mid-stream reset: assert reset for 1 cycle at outPC=20 -> outValid=0 and fetchCount=0 next cycle; sequence restarts at PC 0 two cycles after deassertion.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor constants and types so the ROM, fetch and decode agree on
// the address and instruction widths and on the reset fetch address.
package proc_pkg;

  localparam int ADDR_W   = 12;
  localparam int INSTR_W  = 32;
  localparam int RESET_PC = 0;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0]  pc_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a synchronous ROM: issues word addresses,
// pairs returned data with its PC and hands it to decode over valid/ready.
module fetch_unit
  import proc_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = ADDR_W,
  parameter int          DATA_WIDTH    = INSTR_W,
  parameter int unsigned RESET_PC      = proc_pkg::RESET_PC
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] romAddr,
  input  logic [DATA_WIDTH-1:0]    romData,
  input  logic                     fetchEnable,
  input  logic                     redirectValid,
  input  logic [ADDRESS_WIDTH-1:0] redirectPC,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [DATA_WIDTH-1:0]    outInstr,
  output logic [ADDRESS_WIDTH-1:0] outPC,
  output logic [31:0]              fetchCount
);

  localparam logic [ADDRESS_WIDTH-1:0] RST_PC = ADDRESS_WIDTH'(RESET_PC);
  localparam logic [ADDRESS_WIDTH-1:0] PC_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  // Word addresses wrap silently at the top of the address space.
  function automatic logic [ADDRESS_WIDTH-1:0] pc_inc(input logic [ADDRESS_WIDTH-1:0] pc);
    return pc + PC_ONE;
  endfunction

  logic [ADDRESS_WIDTH-1:0] pc_p0;
  logic [ADDRESS_WIDTH-1:0] resp_pc_p1;
  logic                     vld_p1;
  logic [31:0]              count_q;
  logic                     stall;
  logic                     accept;

  // Stage p0 -> ROM: choose the address the ROM registers at the next edge.
  always_comb begin
    outValid = vld_p1 && !redirectValid && !reset;
    stall    = outValid && !outReady;
    accept   = outValid && outReady;
    romAddr  = pc_p0;
    if (reset) begin
      romAddr = RST_PC;
    end else if (redirectValid) begin
      romAddr = redirectPC;
    end else if (stall) begin
      // Re-read the held word so romData stays put while decode is busy.
      romAddr = resp_pc_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0      <= RST_PC;
      resp_pc_p1 <= RST_PC;
      vld_p1     <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      if (accept) begin
        count_q <= count_q + 32'd1;
      end
      if (redirectValid) begin
        resp_pc_p1 <= redirectPC;
        vld_p1     <= 1'b1;
        pc_p0      <= pc_inc(redirectPC);
      end else if (stall) begin
        vld_p1 <= vld_p1;
      end else if (!fetchEnable) begin
        vld_p1 <= 1'b0;
      end else begin
        resp_pc_p1 <= pc_p0;
        vld_p1     <= 1'b1;
        pc_p0      <= pc_inc(pc_p0);
      end
    end
  end

  // Stage p1 -> decode: ROM data is paired with the PC that requested it.
  assign outInstr   = romData;
  assign outPC      = resp_pc_p1;
  assign fetchCount = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a behavioural ROM holding Mem[i]=i+100
// and a scoreboard of PCs expected to be accepted by decode.
module tb_fetch_unit;
  import proc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, fetchEnable, redirectValid, outReady, outValid;
  pc_t         romAddr, redirectPC, outPC;
  instr_t      romData, outInstr;
  logic [31:0] fetchCount;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_count;
  pc_t         exp_q[$];
  logic        prev_stall = 1'b0;
  pc_t         prev_pc;
  instr_t      prev_instr;

  fetch_unit #(.ADDRESS_WIDTH(ADDR_W), .DATA_WIDTH(INSTR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .romAddr(romAddr), .romData(romData),
    .fetchEnable(fetchEnable), .redirectValid(redirectValid), .redirectPC(redirectPC),
    .outValid(outValid), .outReady(outReady), .outInstr(outInstr), .outPC(outPC),
    .fetchCount(fetchCount)
  );

  always @(posedge clk) romData <= 32'(romAddr) + 32'd100;

  // Mid-cycle monitor: hold-stability under back-pressure and in-order delivery.
  always @(negedge clk) begin
    if (prev_stall) begin
      vectors++;
      if (outPC !== prev_pc || outInstr !== prev_instr) begin
        miscompares++;
        $display("FAIL hold_stable: got pc=%0d instr=%0d expected pc=%0d instr=%0d", outPC, outInstr, prev_pc, prev_instr);
      end
    end
    prev_stall = outValid && !outReady;
    prev_pc    = outPC;
    prev_instr = outInstr;
    if (outValid && outReady) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_accept: got pc=%0d expected no handshake", outPC);
      end else begin
        pc_t e;
        e = exp_q.pop_front();
        if (outPC !== e || outInstr !== 32'(e) + 32'd100) begin
          miscompares++;
          $display("FAIL sb_order: got pc=%0d instr=%0d expected pc=%0d instr=%0d", outPC, outInstr, e, 32'(e) + 32'd100);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetchEnable = 1'b1; redirectValid = 1'b0; redirectPC = '0; outReady = 1'b1;
    repeat (2) cycle();
    #1;
    vectors++;
    if (outValid !== 1'b0 || romAddr !== pc_t'(0) || fetchCount !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b addr=%0d cnt=%0d expected 0 0 0", outValid, romAddr, fetchCount);
    end
    reset = 1'b0; exp_count = 32'd0;
    #1;
    vectors++;
    if (outValid !== 1'b0 || romAddr !== pc_t'(0)) begin
      miscompares++;
      $display("FAIL first_issue: got valid=%b addr=%0d expected 0 0", outValid, romAddr);
    end
    cycle();
  endtask

  task automatic test_run();
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (outValid !== 1'b1 || outPC !== pc_t'(k) || outInstr !== 32'(k + 100) || fetchCount !== exp_count) begin
        miscompares++;
        $display("FAIL stream: got v=%b pc=%0d instr=%0d cnt=%0d expected 1 %0d %0d %0d", outValid, outPC, outInstr, fetchCount, k, k + 100, exp_count);
      end
      exp_q.push_back(pc_t'(k)); exp_count++;
      cycle();
    end
  endtask

  task automatic test_backpressure();
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (outValid !== 1'b1 || outPC !== pc_t'(5) || outInstr !== 32'd105 || romAddr !== pc_t'(5) || fetchCount !== exp_count) begin
        miscompares++;
        $display("FAIL stall_hold: got v=%b pc=%0d instr=%0d addr=%0d cnt=%0d expected 1 5 105 5 %0d", outValid, outPC, outInstr, romAddr, fetchCount, exp_count);
      end
      cycle();
    end
    outReady = 1'b1;
    for (int k = 5; k < 10; k++) begin
      #1;
      vectors++;
      if (outValid !== 1'b1 || outPC !== pc_t'(k) || fetchCount !== exp_count) begin
        miscompares++;
        $display("FAIL stall_release: got v=%b pc=%0d cnt=%0d expected 1 %0d %0d", outValid, outPC, fetchCount, k, exp_count);
      end
      exp_q.push_back(pc_t'(k)); exp_count++;
      cycle();
    end
  endtask

  task automatic test_redirect();
    redirectValid = 1'b1; redirectPC = pc_t'(40);
    #1;
    vectors++;
    if (outValid !== 1'b0 || romAddr !== pc_t'(40) || outPC !== pc_t'(10)) begin
      miscompares++;
      $display("FAIL redirect_squash: got v=%b addr=%0d pc=%0d expected 0 40 10", outValid, romAddr, outPC);
    end
    cycle();
    redirectValid = 1'b0;
    for (int k = 40; k < 42; k++) begin
      #1;
      vectors++;
      if (outValid !== 1'b1 || outPC !== pc_t'(k) || outInstr !== 32'(k + 100) || fetchCount !== exp_count) begin
        miscompares++;
        $display("FAIL redirect_target: got v=%b pc=%0d instr=%0d cnt=%0d expected 1 %0d %0d %0d", outValid, outPC, outInstr, fetchCount, k, k + 100, exp_count);
      end
      exp_q.push_back(pc_t'(k)); exp_count++;
      cycle();
    end
  endtask

  task automatic test_redirect_stall();
    redirectValid = 1'b1; redirectPC = pc_t'(7);
    cycle();
    redirectValid = 1'b0; outReady = 1'b0;
    #1;
    vectors++;
    if (outValid !== 1'b1 || outPC !== pc_t'(7) || romAddr !== pc_t'(7)) begin
      miscompares++;
      $display("FAIL rs_setup: got v=%b pc=%0d addr=%0d expected 1 7 7", outValid, outPC, romAddr);
    end
    cycle();
    redirectValid = 1'b1; redirectPC = pc_t'(2);
    #1;
    vectors++;
    if (outValid !== 1'b0 || romAddr !== pc_t'(2)) begin
      miscompares++;
      $display("FAIL rs_squash: got v=%b addr=%0d expected 0 2", outValid, romAddr);
    end
    cycle();
    redirectValid = 1'b0; outReady = 1'b1;
    for (int k = 2; k < 4; k++) begin
      #1;
      vectors++;
      if (outValid !== 1'b1 || outPC !== pc_t'(k) || outInstr !== 32'(k + 100) || fetchCount !== exp_count) begin
        miscompares++;
        $display("FAIL rs_target: got v=%b pc=%0d instr=%0d cnt=%0d expected 1 %0d %0d %0d", outValid, outPC, outInstr, fetchCount, k, k + 100, exp_count);
      end
      exp_q.push_back(pc_t'(k)); exp_count++;
      cycle();
    end
  endtask

  task automatic test_wrap_enable();
    pc_t seq [2];
    redirectValid = 1'b1; redirectPC = pc_t'(4095);
    cycle();
    redirectValid = 1'b0;
    seq[0] = pc_t'(4095); seq[1] = pc_t'(0);
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (outValid !== 1'b1 || outPC !== seq[i] || outInstr !== 32'(seq[i]) + 32'd100) begin
        miscompares++;
        $display("FAIL wrap: got v=%b pc=%0d instr=%0d expected 1 %0d %0d", outValid, outPC, outInstr, seq[i], 32'(seq[i]) + 32'd100);
      end
      exp_q.push_back(seq[i]); exp_count++;
      cycle();
    end
    fetchEnable = 1'b0;
    #1;
    vectors++;
    if (outValid !== 1'b1 || outPC !== pc_t'(1) || romAddr !== pc_t'(2)) begin
      miscompares++;
      $display("FAIL disable_consume: got v=%b pc=%0d addr=%0d expected 1 1 2", outValid, outPC, romAddr);
    end
    exp_q.push_back(pc_t'(1)); exp_count++;
    cycle();
    for (int i = 0; i < 2; i++) begin
      if (i == 1) fetchEnable = 1'b1;
      #1;
      vectors++;
      if (outValid !== 1'b0 || romAddr !== pc_t'(2)) begin
        miscompares++;
        $display("FAIL disabled_gap: got v=%b addr=%0d expected 0 2", outValid, romAddr);
      end
      cycle();
    end
    #1;
    vectors++;
    if (outValid !== 1'b1 || outPC !== pc_t'(2) || fetchCount !== exp_count) begin
      miscompares++;
      $display("FAIL enable_resume: got v=%b pc=%0d cnt=%0d expected 1 2 %0d", outValid, outPC, fetchCount, exp_count);
    end
    exp_q.push_back(pc_t'(2)); exp_count++;
    cycle();
  endtask

  task automatic test_mid_reset();
    redirectValid = 1'b1; redirectPC = pc_t'(19);
    cycle();
    redirectValid = 1'b0;
    exp_q.push_back(pc_t'(19)); exp_count++;
    cycle();
    #1;
    vectors++;
    if (outValid !== 1'b1 || outPC !== pc_t'(20)) begin
      miscompares++;
      $display("FAIL mr_setup: got v=%b pc=%0d expected 1 20", outValid, outPC);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (outValid !== 1'b0 || romAddr !== pc_t'(0)) begin
      miscompares++;
      $display("FAIL mr_during: got v=%b addr=%0d expected 0 0", outValid, romAddr);
    end
    cycle();
    reset = 1'b0; exp_count = 32'd0;
    #1;
    vectors++;
    if (outValid !== 1'b0 || fetchCount !== 32'd0) begin
      miscompares++;
      $display("FAIL mr_after: got v=%b cnt=%0d expected 0 0", outValid, fetchCount);
    end
    cycle();
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (outValid !== 1'b1 || outPC !== pc_t'(k) || fetchCount !== exp_count) begin
        miscompares++;
        $display("FAIL mr_restart: got v=%b pc=%0d cnt=%0d expected 1 %0d %0d", outValid, outPC, fetchCount, k, exp_count);
      end
      exp_q.push_back(pc_t'(k)); exp_count++;
      cycle();
    end
  endtask

  task automatic test_back_to_back();
    bit drained = 1'b0;
    for (int k = 2; k < 32; k++) exp_q.push_back(pc_t'(k));
    exp_count = exp_count + 32'd30;
    for (int c = 0; c < 400; c++) begin
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
      outReady    = 1'($urandom_range(0, 1));
      fetchEnable = ($urandom_range(0, 3) != 0);
      cycle();
    end
    outReady = 1'b0; fetchEnable = 1'b1;
    vectors++;
    if (!drained) begin
      miscompares++;
      $display("FAIL b2b_timeout: got %0d pending expected 0", exp_q.size());
    end
    #1;
    vectors++;
    if (fetchCount !== exp_count) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d expected %0d", fetchCount, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_backpressure();
    test_redirect();
    test_redirect_stall();
    test_wrap_enable();
    test_mid_reset();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
